// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream in and RAM write port out of the program loader.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            RX_DATA;
    logic                  RX_VALID;
    logic                  RX_READY;
    logic [ADDR_WIDTH-1:0] ADDR_W;
    logic                  ENABLE_W;
    logic [DATA_WIDTH-1:0] Q_W;
    modport master (output RX_DATA, RX_VALID, input RX_READY, ADDR_W, ENABLE_W, Q_W);
    modport slave  (input RX_DATA, RX_VALID, output RX_READY, ADDR_W, ENABLE_W, Q_W);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a framed byte image (length, LE words, checksum) into RAM
// and holds the core in reset until a load finishes with a matching checksum.
module prog_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BASE_ADDR  = 0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    prog_loader_if.slave bus,
    output logic         CPU_RESET,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERROR,
    output logic [15:0]  WORDS_LOADED
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int IW = BPW > 1 ? $clog2(BPW) : 1;
    localparam longint CAP = (longint'(1) << ADDR_WIDTH) - longint'(BASE_ADDR);
    typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR} state_t;
    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d, wcnt_q, wcnt_d, words_q, words_d, len_new;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d, q_w_q, q_w_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            chk_q, chk_d;
    logic                  en_q, en_d, rdy_q, rdy_d, xfer;
    always_comb begin
        xfer = bus.RX_VALID && rdy_q;
        len_new = {bus.RX_DATA, len_q[7:0]};
        state_d = state_q;
        len_d = len_q;
        wcnt_d = wcnt_q;
        idx_d = idx_q;
        buf_d = buf_q;
        q_w_d = q_w_q;
        chk_d = chk_q;
        en_d = 1'b0;
        // address and word count advance the cycle after each strobe
        addr_d = en_q ? addr_q + 1'b1 : addr_q;
        words_d = en_q ? words_q + 16'd1 : words_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (START) begin
                state_d = S_LEN_LO;
                chk_d = '0;
                addr_d = ADDR_WIDTH'(BASE_ADDR);
                words_d = '0;
                wcnt_d = '0;
                idx_d = '0;
            end
            S_LEN_LO: if (xfer) begin
                len_d = {8'h00, bus.RX_DATA};
                state_d = S_LEN_HI;
            end
            S_LEN_HI: if (xfer) begin
                len_d = len_new;
                state_d = longint'(len_new) > CAP ? S_ERR : len_new == 16'd0 ? S_CHECK : S_DATA;
            end
            S_DATA: if (xfer) begin
                buf_d[8*int'(idx_q) +: 8] = bus.RX_DATA;
                chk_d = chk_q + bus.RX_DATA;
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(BPW - 1)) begin
                    idx_d = '0;
                    en_d = 1'b1;
                    q_w_d = buf_d;
                    wcnt_d = wcnt_q + 16'd1;
                    state_d = wcnt_d == len_q ? S_CHECK : S_DATA;
                end
            end
            S_CHECK: if (xfer) state_d = bus.RX_DATA == chk_q ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
        rdy_d = state_d inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            len_q <= '0;
            wcnt_q <= '0;
            words_q <= '0;
            idx_q <= '0;
            buf_q <= '0;
            q_w_q <= '0;
            addr_q <= ADDR_WIDTH'(BASE_ADDR);
            chk_q <= '0;
            en_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            wcnt_q <= wcnt_d;
            words_q <= words_d;
            idx_q <= idx_d;
            buf_q <= buf_d;
            q_w_q <= q_w_d;
            addr_q <= addr_d;
            chk_q <= chk_d;
            en_q <= en_d;
            rdy_q <= rdy_d;
        end
    end
    assign bus.RX_READY = rdy_q;
    assign bus.ENABLE_W = en_q;
    assign bus.ADDR_W = addr_q;
    assign bus.Q_W = q_w_q;
    assign BUSY = rdy_q;
    assign CPU_RESET = state_q != S_DONE;
    assign DONE = state_q == S_DONE;
    assign ERROR = state_q == S_ERR;
    assign WORDS_LOADED = words_q;
endmodule
